prio_deco: RTL

Sequential grant decoder, the receiving end of the 4-bit priority-encoder interface. It accepts an encoded request index (2-bit index plus valid) through a valid/ready handshake and decodes it into a registered one-hot grant. It holds that grant until the selected requester acknowledges or a timeout expires. It sits downstream of the priority encoder and drives per-requester grant lines in the arbitration path.

---
 rtl/prio_deco.sv | 117 +++++++++++
 1 files changed

// File: rtl/prio_deco.sv
// Sequential grant decoder: accepts an encoded 2-bit request index over valid/ready
// and holds a registered one-hot grant until the matching ack arrives or TIMEOUT expires.
module prio_deco #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] in_idx,
  output logic       in_ready,
  input  logic [3:0] ack,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout,
  output logic [7:0] grant_cnt,
  output logic [1:0] dbg_state
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_COOL  = 2'd2
  } state_t;

  // Handshake: a request transfers on the rising edge where in_valid && in_ready;
  // the source must hold in_idx stable while in_valid=1 and in_ready=0.

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]      r_grant, w_grant_nxt;
  logic            r_busy;
  logic            r_timeout, w_timeout_nxt;
  logic [7:0]      r_grant_cnt, w_grant_cnt_nxt;
  logic            w_ack_hit;
  logic            w_limit;

  assign w_ack_hit = ack[r_idx];
  assign w_limit   = (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_grant_nxt     = r_grant;
    w_timeout_nxt   = 1'b0;
    w_grant_cnt_nxt = r_grant_cnt;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = 4'b0000;
        if (in_valid) begin
          w_state_nxt = S_GRANT;
          w_idx_nxt   = in_idx;
          w_cnt_nxt   = '0;
          case (in_idx)
            2'd0:    w_grant_nxt = 4'b0001;
            2'd1:    w_grant_nxt = 4'b0010;
            2'd2:    w_grant_nxt = 4'b0100;
            default: w_grant_nxt = 4'b1000;
          endcase
        end
      end
      S_GRANT: begin
        // Ack takes priority over the limit when both land on the same edge.
        if (w_ack_hit) begin
          w_state_nxt     = S_COOL;
          w_grant_nxt     = 4'b0000;
          w_grant_cnt_nxt = r_grant_cnt + 8'd1;
        end else if (w_limit) begin
          w_state_nxt   = S_COOL;
          w_grant_nxt   = 4'b0000;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_COOL: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'b0000;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= '0;
      r_grant     <= 4'b0000;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_grant_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_grant     <= w_grant_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_timeout   <= w_timeout_nxt;
      r_grant_cnt <= w_grant_cnt_nxt;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign grant     = r_grant;
  assign busy      = r_busy;
  assign timeout   = r_timeout;
  assign grant_cnt = r_grant_cnt;
  assign dbg_state = r_state;

endmodule
